// File: rtl/adc_spi_resp_pkg.sv
// rtl/adc_spi_resp_pkg.sv - shared types and instruction field layout for adc_spi_responder
package adc_spi_resp_pkg;

    typedef enum logic [2:0] {IDLE, INSTR, WR, RD, DONE} state_t;

    localparam int         INSTR_BITS = 16;
    localparam logic [1:0] STREAM_W   = 2'b11;

    localparam int RW_BIT   = 15;
    localparam int W_MSB    = 14;
    localparam int W_LSB    = 13;
    localparam int ADDR_MSB = 12;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - 3-stage pin synchronizer with rise/fall detect
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [2:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {3{RST_VAL}};
        end else begin
            r_sync <= {r_sync[1:0], i_pin};
        end
    end

    // Stage 1 is the level; stage 2 only serves the edge compare.
    assign o_level = r_sync[1];
    assign o_rise  = r_sync[1] & ~r_sync[2];
    assign o_fall  = ~r_sync[1] & r_sync[2];

endmodule

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - 3-wire SPI config-port responder with byte register file
// ADC_SPI_RESP_SHADOW_EN: SPI writes go to a shadow array, published by the top-address transfer bit.
module adc_spi_responder
    import adc_spi_resp_pkg::*;
#(
    parameter int         aw        = 6,
    parameter logic [7:0] reset_val = 8'h00
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sclk,
    input  logic          csb,
    input  logic          sdio_in,
    output logic          sdio_out,
    output logic          sdio_oe,
    input  logic [aw-1:0] reg_addr,
    output logic [7:0]    reg_dout,
    output logic          wr_strobe,
    output logic [aw-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          frame_err,
    output logic          busy
);

    localparam int NREG = 1 << aw;

    state_t        r_state;
    logic [3:0]    r_bit_cnt;
    logic [14:0]   r_shift;
    logic [12:0]   r_addr;
    logic [1:0]    r_left;
    logic          r_stream;
    logic          r_rd_pend;
    logic [6:0]    r_tx;
    logic          r_sdio_out;
    logic          r_oe;
    logic          r_wr_strobe;
    logic [aw-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic          r_frame_err;
    logic [7:0]    r_reg_dout;
    logic [1:0]    r_sdio_s;
    logic [7:0]    r_active [NREG];

    logic w_sclk_rise, w_sclk_fall, w_sclk_unused;
    logic w_csb_s, w_csb_rise, w_csb_fall;

    spi_pin_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .i_pin(sclk),
        .o_level(w_sclk_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_pin_sync #(.RST_VAL(1'b1)) u_csb_sync (
        .clk(clk), .rst_n(rst_n), .i_pin(csb),
        .o_level(w_csb_s), .o_rise(w_csb_rise), .o_fall(w_csb_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sdio_s <= 2'b00;
        end else begin
            r_sdio_s <= {r_sdio_s[0], sdio_in};
        end
    end

    logic          w_sdio;
    logic [15:0]   w_full;
    logic [7:0]    w_byte;
    logic          w_in_range;
    logic [aw-1:0] w_idx;
    logic          w_byte_done;
    logic          w_commit;
    logic          w_last;
    logic [7:0]    w_rd_byte;

    assign w_sdio      = r_sdio_s[1];
    assign w_full      = {r_shift, w_sdio};
    assign w_byte      = {r_shift[6:0], w_sdio};
    assign w_in_range  = (r_addr >> aw) == 13'd0;
    assign w_idx       = r_addr[aw-1:0];
    assign w_byte_done = (r_state == WR || r_state == RD) && w_sclk_rise && (r_bit_cnt == 4'd7);
    assign w_commit    = (r_state == WR) && w_byte_done && w_in_range;
    assign w_last      = !r_stream && (r_left == 2'd0);
    assign w_rd_byte   = w_in_range ? r_active[w_idx] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 15'd0;
            r_addr      <= 13'd0;
            r_left      <= 2'd0;
            r_stream    <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_tx        <= 7'd0;
            r_sdio_out  <= 1'b0;
            r_oe        <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_strobe <= w_commit;
            if (w_commit) begin
                r_wr_addr <= w_idx;
                r_wr_data <= w_byte;
            end
            // A byte completing on the same edge csb rises is a clean end, not a framing error.
            r_frame_err <= w_csb_rise && ((r_state == INSTR) ||
                           ((r_state == WR || r_state == RD) && r_bit_cnt != 4'd0 && !w_byte_done));

            if (w_csb_s) begin
                r_state <= IDLE;
                r_oe    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_csb_fall) begin
                            r_state   <= INSTR;
                            r_bit_cnt <= 4'd0;
                        end
                    end
                    INSTR: begin
                        if (w_sclk_rise) begin
                            r_shift   <= w_full[14:0];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'(INSTR_BITS - 1)) begin
                                r_bit_cnt <= 4'd0;
                                r_addr    <= w_full[ADDR_MSB:0];
                                r_left    <= w_full[W_MSB:W_LSB];
                                r_stream  <= (w_full[W_MSB:W_LSB] == STREAM_W);
                                r_rd_pend <= 1'b1;
                                r_state   <= w_full[RW_BIT] ? RD : WR;
                            end
                        end
                    end
                    WR: begin
                        if (w_sclk_rise) begin
                            r_shift   <= w_full[14:0];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= 4'd0;
                                r_addr    <= r_addr - 13'd1;
                                if (w_last) begin
                                    r_state <= DONE;
                                end else begin
                                    r_left <= r_left - 2'd1;
                                end
                            end
                        end
                    end
                    RD: begin
                        // The master samples on rising edges, so the byte boundary is counted there.
                        if (w_sclk_fall) begin
                            r_oe <= 1'b1;
                            if (r_rd_pend) begin
                                r_sdio_out <= w_rd_byte[7];
                                r_tx       <= w_rd_byte[6:0];
                                r_rd_pend  <= 1'b0;
                            end else begin
                                r_sdio_out <= r_tx[6];
                                r_tx       <= {r_tx[5:0], 1'b0};
                            end
                        end
                        if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= 4'd0;
                                r_addr    <= r_addr - 13'd1;
                                r_rd_pend <= 1'b1;
                                if (w_last) begin
                                    r_state <= DONE;
                                    r_oe    <= 1'b0;
                                end else begin
                                    r_left <= r_left - 2'd1;
                                end
                            end
                        end
                    end
                    DONE: begin
                        r_oe <= 1'b0;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef ADC_SPI_RESP_SHADOW_EN
    logic [7:0] r_shadow [NREG];
    logic       r_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_active[i] <= reset_val;
                r_shadow[i] <= reset_val;
            end
            r_xfer <= 1'b0;
        end else begin
            r_xfer <= w_commit && (w_idx == {aw{1'b1}}) && w_byte[0];
            if (r_xfer) begin
                for (int i = 0; i < NREG; i++) begin
                    r_active[i] <= r_shadow[i];
                end
                r_active[NREG-1][0] <= 1'b0;
                r_shadow[NREG-1][0] <= 1'b0;
            end
            if (w_commit) begin
                r_shadow[w_idx] <= w_byte;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_active[i] <= reset_val;
            end
        end else if (w_commit) begin
            r_active[w_idx] <= w_byte;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_dout <= 8'h00;
        end else begin
            r_reg_dout <= r_active[reg_addr];
        end
    end

    assign sdio_out  = r_sdio_out;
    assign sdio_oe   = r_oe;
    assign reg_dout  = r_reg_dout;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - directed self-checking bench for adc_spi_responder
module tb_adc_spi_responder;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       sclk    = 1'b0;
    logic       csb     = 1'b1;
    logic       sdio_in = 1'b0;
    logic       sdio_out, sdio_oe, wr_strobe, frame_err, busy;
    logic [5:0] reg_addr = 6'd0;
    logic [5:0] wr_addr;
    logic [7:0] reg_dout, wr_data;

    int checks = 0;
    int errors = 0;
    int n_strb = 0;
    int n_ferr = 0;
    logic [5:0] log_addr [0:63];
    logic [7:0] log_data [0:63];

    always #5 clk = ~clk;

    adc_spi_responder #(.aw(6), .reset_val(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .csb(csb), .sdio_in(sdio_in),
        .sdio_out(sdio_out), .sdio_oe(sdio_oe), .reg_addr(reg_addr), .reg_dout(reg_dout),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_err(frame_err), .busy(busy)
    );

    always @(negedge clk) begin
        if (wr_strobe) begin
            if (n_strb < 64) begin
                log_addr[n_strb] = wr_addr;
                log_data[n_strb] = wr_data;
            end
            n_strb = n_strb + 1;
        end
        if (frame_err) n_ferr = n_ferr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_begin();
        csb = 1'b0;
        #60;
    endtask

    task automatic spi_end();
        #60;
        csb = 1'b1;
        #120;
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdio_in = v[i];
            #60; sclk = 1'b1;
            #60; sclk = 1'b0;
        end
    endtask

    task automatic read_byte(output logic [7:0] b, output logic oe_all);
        oe_all = 1'b1;
        b = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            #60;
            b[i]   = sdio_out;
            oe_all = oe_all & sdio_oe;
            sclk = 1'b1;
            #60; sclk = 1'b0;
        end
    endtask

    task automatic write_txn(input logic [15:0] instr, input logic [7:0] data);
        spi_begin();
        send_bits(instr, 16);
        send_bits({8'h00, data}, 8);
        spi_end();
    endtask

    task automatic fab_read(input logic [5:0] a, output logic [7:0] d);
        reg_addr = a;
        @(posedge clk);
        @(negedge clk);
        d = reg_dout;
    endtask

    task automatic publish();
`ifdef ADC_SPI_RESP_SHADOW_EN
        write_txn(16'h003F, 8'h01);
`endif
    endtask

    logic [7:0] d;
    logic       oe_ok;
    int         s0, f0;

    initial begin
        #20;
        check("rst_sdio_oe", sdio_oe, 0);
        check("rst_sdio_out", sdio_out, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        #40;
        fab_read(6'd5, d);
        check("rst_reg5", d, 8'h00);

        s0 = n_strb;
        spi_begin();
        check("w0_busy", busy, 1);
        send_bits(16'h0005, 16);
        send_bits(16'h00A5, 8);
        spi_end();
        check("w0_strb_cnt", n_strb - s0, 1);
        check("w0_addr", log_addr[s0], 6'd5);
        check("w0_data", log_data[s0], 8'hA5);
        check("w0_ferr", n_ferr, 0);
        check("w0_idle", busy, 0);
        publish();
        fab_read(6'd5, d);
        check("w0_reg5", d, 8'hA5);

        s0 = n_strb;
        spi_begin();
        send_bits(16'h6002, 16);
        send_bits(16'h0011, 8);
        send_bits(16'h0022, 8);
        send_bits(16'h0033, 8);
        send_bits(16'h0044, 8);
        spi_end();
        check("ws_strb_cnt", n_strb - s0, 3);
        check("ws_addr0", log_addr[s0], 6'd2);
        check("ws_data0", log_data[s0], 8'h11);
        check("ws_addr1", log_addr[s0+1], 6'd1);
        check("ws_data1", log_data[s0+1], 8'h22);
        check("ws_addr2", log_addr[s0+2], 6'd0);
        check("ws_data2", log_data[s0+2], 8'h33);
        check("ws_ferr", n_ferr, 0);
        publish();
        fab_read(6'd0, d);
        check("ws_reg0", d, 8'h33);
        fab_read(6'd63, d);
        check("ws_reg63_no_alias", d, 8'h00);

        write_txn(16'h0003, 8'h3C);
        publish();
        s0 = n_strb;
        spi_begin();
        send_bits(16'hA003, 16);
        check("rd_oe_before_fall", sdio_oe, 0);
        read_byte(d, oe_ok);
        check("rd_byte0", d, 8'h3C);
        check("rd_oe_byte0", oe_ok, 1);
        read_byte(d, oe_ok);
        check("rd_byte1", d, 8'h11);
        check("rd_oe_byte1", oe_ok, 1);
        check("rd_oe_after", sdio_oe, 0);
        check("rd_done_busy", busy, 1);
        spi_end();
        check("rd_sdio_hold", sdio_out, 1);
        check("rd_idle", busy, 0);
        check("rd_no_strb", n_strb - s0, 0);
        check("rd_ferr", n_ferr, 0);

        f0 = n_ferr;
        s0 = n_strb;
        spi_begin();
        send_bits(16'h0107 >> 6, 10);
        spi_end();
        check("fe_instr", n_ferr - f0, 1);
        check("fe_instr_idle", busy, 0);
        spi_begin();
        send_bits(16'h0006, 16);
        send_bits(16'h001F, 5);
        spi_end();
        check("fe_data", n_ferr - f0, 2);
        check("fe_no_strb", n_strb - s0, 0);
        fab_read(6'd6, d);
        check("fe_reg6", d, 8'h00);
        fab_read(6'd5, d);
        check("fe_reg5_kept", d, 8'hA5);

        spi_begin();
        send_bits(16'h8005, 16);
        for (int i = 0; i < 4; i++) begin
            #60; sclk = 1'b1;
            #60; sclk = 1'b0;
        end
        #60;
        check("mr_oe_active", sdio_oe, 1);
        rst_n = 1'b0;
        #10;
        check("mr_oe", sdio_oe, 0);
        check("mr_busy", busy, 0);
        check("mr_sdio_out", sdio_out, 0);
        csb = 1'b1;
        #20;
        rst_n = 1'b1;
        #40;
        fab_read(6'd5, d);
        check("mr_reg5", d, 8'h00);
        fab_read(6'd2, d);
        check("mr_reg2", d, 8'h00);
        fab_read(6'd3, d);
        check("mr_reg3", d, 8'h00);

        write_txn(16'h0004, 8'h77);
        fab_read(6'd4, d);
`ifdef ADC_SPI_RESP_SHADOW_EN
        check("sh_reg4_pre", d, 8'h00);
`else
        check("sh_reg4_pre", d, 8'h77);
`endif
        write_txn(16'h003F, 8'h01);
        fab_read(6'd4, d);
        check("sh_reg4_post", d, 8'h77);
        fab_read(6'd63, d);
`ifdef ADC_SPI_RESP_SHADOW_EN
        check("sh_reg63", d, 8'h00);
`else
        check("sh_reg63", d, 8'h01);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
